// File: rtl/imem_responder.sv
// Pipelined instruction-memory responder: valid/ready fetch requests, fixed-latency
// array read, credit-limited in-order response FIFO, preload port and flush.
module imem_responder #(
  parameter int                DWIDTH     = 32,
  parameter int                AWIDTH     = 32,
  parameter logic [AWIDTH-1:0] BASEADDR   = {AWIDTH{1'b0}},
  parameter int                MEM_WORDS  = 1024,
  parameter int                LATENCY    = 2,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [AWIDTH-1:0] rsp_addr_o,
  output logic [DWIDTH-1:0] rsp_insn_o,
  output logic              rsp_fault_o,
  input  logic              flush_i,
  input  logic              load_en_i,
  input  logic [AWIDTH-1:0] load_addr_i,
  input  logic [DWIDTH-1:0] load_data_i
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [DWIDTH-1:0] NOP = DWIDTH'(32'h0000_0013);

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
    logic              fault;
  } rsp_t;

  // Word offsets are formed from the upper address bits so misalignment is judged on the raw address.
  function automatic logic addr_fault(input logic [AWIDTH-1:0] addr,
                                      input logic [AWIDTH-3:0] word_off);
    logic bad;
    bad = 1'b0;
    if (addr[1:0] != 2'b00) begin
      bad = 1'b1;
    end else if (addr < BASEADDR) begin
      bad = 1'b1;
    end else if (word_off >= (AWIDTH-2)'(MEM_WORDS)) begin
      bad = 1'b1;
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  logic [DWIDTH-1:0] mem [MEM_WORDS];

  logic [AWIDTH-3:0] req_word;
  logic [AWIDTH-3:0] load_word;
  logic [IW-1:0]     req_idx;
  logic [IW-1:0]     load_idx;
  logic              req_fault;
  logic              load_fault;

  logic [CW-1:0]     credits;
  logic              accept;
  logic              pop;

  rsp_t              acc_entry;
  rsp_t              wr_entry;
  logic              wr_valid;

  rsp_t              fifo_mem [FIFO_DEPTH];
  rsp_t              head;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  assign req_word   = req_addr_i[AWIDTH-1:2] - BASEADDR[AWIDTH-1:2];
  assign load_word  = load_addr_i[AWIDTH-1:2] - BASEADDR[AWIDTH-1:2];
  assign req_idx    = req_word[IW-1:0];
  assign load_idx   = load_word[IW-1:0];
  assign req_fault  = addr_fault(req_addr_i, req_word);
  assign load_fault = addr_fault(load_addr_i, load_word);

  // Preload port; writes land at the edge, so a same-cycle read still sees the old word.
  always_ff @(posedge clk) begin
    if (load_en_i && !load_fault) begin
      mem[load_idx] <= load_data_i;
    end
  end

  // Ready looks at the credit count after this cycle's pop, letting a full FIFO refill immediately.
  always_comb begin
    req_ready_o = 1'b0;
    if (rst || flush_i) begin
      req_ready_o = 1'b0;
    end else if (credits < CW'(FIFO_DEPTH)) begin
      req_ready_o = 1'b1;
    end else if (pop) begin
      req_ready_o = 1'b1;
    end else begin
      req_ready_o = 1'b0;
    end
  end

  assign accept = req_valid_i && req_ready_o;
  assign pop    = rsp_valid_o && rsp_ready_i;

  // Outstanding-response credit counter.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      credits <= {CW{1'b0}};
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Response payload formed in the accept cycle.
  always_comb begin
    acc_entry       = '0;
    acc_entry.addr  = req_addr_i;
    acc_entry.fault = req_fault;
    if (req_fault) begin
      acc_entry.data = NOP;
    end else begin
      acc_entry.data = mem[req_idx];
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign wr_valid = accept;
      assign wr_entry = acc_entry;
    end else begin : g_pipe
      logic pipe_valid [1:LATENCY-1];
      rsp_t pipe_data  [1:LATENCY-1];

      // Pipeline valid bits; these are the in-flight responses a flush discards.
      always_ff @(posedge clk) begin
        if (rst || flush_i) begin
          for (int k = 1; k < LATENCY; k++) begin
            pipe_valid[k] <= 1'b0;
          end
        end else begin
          pipe_valid[1] <= accept;
          for (int k = 2; k < LATENCY; k++) begin
            pipe_valid[k] <= pipe_valid[k-1];
          end
        end
      end

      // Pipeline payload, qualified only by the valid bits.
      always_ff @(posedge clk) begin
        pipe_data[1] <= acc_entry;
        for (int k = 2; k < LATENCY; k++) begin
          pipe_data[k] <= pipe_data[k-1];
        end
      end

      assign wr_valid = pipe_valid[LATENCY-1];
      assign wr_entry = pipe_data[LATENCY-1];
    end
  endgenerate

  // FIFO storage; credits guarantee a slot is free whenever an entry arrives.
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      fifo_mem[wr_ptr] <= wr_entry;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (wr_valid) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_valid, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rsp_valid_o = !rst && (count != {CW{1'b0}});
  assign head        = fifo_mem[rd_ptr];

  // Head fields are zeroed whenever nothing is presented.
  always_comb begin
    rsp_addr_o  = {AWIDTH{1'b0}};
    rsp_insn_o  = {DWIDTH{1'b0}};
    rsp_fault_o = 1'b0;
    if (rsp_valid_o) begin
      rsp_addr_o  = head.addr;
      rsp_insn_o  = head.data;
      rsp_fault_o = head.fault;
    end else begin
      rsp_addr_o  = {AWIDTH{1'b0}};
      rsp_insn_o  = {DWIDTH{1'b0}};
      rsp_fault_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: preload, backpressure/full, faults, flush,
// load/read collision and reset mid-stream, with hand-computed expectations.
module tb_imem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_insn;
  logic        rsp_fault;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [8];
  logic [31:0] fa [3];

  imem_responder #(
    .DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE),
    .MEM_WORDS(1024), .LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_addr_o(rsp_addr), .rsp_insn_o(rsp_insn), .rsp_fault_o(rsp_fault),
    .flush_i(flush), .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] a, input logic [31:0] d, input logic f);
    chk1({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_addr"}, rsp_addr, a);
    chk({tag, "_insn"}, rsp_insn, d);
    chk1({tag, "_fault"}, rsp_fault, f);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int j;
    int h;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
    flush = 1'b0; load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;
    fa[0] = BASE + 32'd2;
    fa[1] = BASE - 32'd4;
    fa[2] = BASE + 32'd4096;
    tick();

    // Preload words 0..7 while reset is held
    for (int i = 0; i < 8; i++) begin
      load_en   = 1'b1;
      load_addr = BASE + 32'(4 * i);
      load_data = (i == 5) ? 32'h0000_0011 : 32'h0000_00A0 + 32'(i);
      model[i]  = load_data;
      #1;
      chk1("rst_ready", req_ready, 1'b0);
      chk1("rst_valid", rsp_valid, 1'b0);
      tick();
    end
    load_en = 1'b0;
    #1;
    chk("rst_addr", rsp_addr, 32'h0);
    chk("rst_insn", rsp_insn, 32'h0);
    chk1("rst_fault", rsp_fault, 1'b0);
    rst = 1'b0;
    #1;
    chk1("post_rst_ready", req_ready, 1'b1);
    chk1("post_rst_valid", rsp_valid, 1'b0);
    tick();

    // Preload sequence: back-to-back fetches, responses at accept+2
    rsp_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 4);
      req_addr  = BASE + 32'(4 * k);
      #1;
      if (k < 4) chk1("seq_ready", req_ready, 1'b1);
      if (k >= 2 && k < 6) chk_rsp("seq_rsp", BASE + 32'(4 * (k - 2)), model[k-2], 1'b0);
      else chk1("seq_idle", rsp_valid, 1'b0);
      tick();
    end
    req_valid = 1'b0;

    // Backpressure and full: 4 accepted, 5th accepted with the first pop
    for (int k = 0; k < 13; k++) begin
      j = (k < 4) ? k : ((k <= 6) ? 4 : 5);
      req_valid = (k <= 7);
      req_addr  = BASE + 32'(4 * j);
      rsp_ready = (k >= 6);
      #1;
      if (k <= 7) chk1("bp_ready", req_ready, (k < 4) || (k >= 6));
      if (k >= 2 && k <= 11) begin
        h = (k < 6) ? 0 : k - 6;
        chk_rsp("bp_rsp", BASE + 32'(4 * h), model[h], 1'b0);
      end else begin
        chk1("bp_idle", rsp_valid, 1'b0);
      end
      tick();
    end
    req_valid = 1'b0;

    // Fault handling
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_valid = (k < 3);
      req_addr  = fa[(k < 3) ? k : 0];
      #1;
      if (k < 3) chk1("flt_ready", req_ready, 1'b1);
      if (k >= 2 && k <= 4) chk_rsp("flt_rsp", fa[k-2], 32'h0000_0013, 1'b1);
      else chk1("flt_idle", rsp_valid, 1'b0);
      tick();
    end
    req_valid = 1'b0;

    // Flush with queued and in-flight responses
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_addr  = BASE + 32'(4 * k);
      #1;
      chk1("fl_fill_ready", req_ready, 1'b1);
      tick();
    end
    flush    = 1'b1;
    req_addr = BASE + 32'd28;
    #1;
    chk1("fl_ready", req_ready, 1'b0);
    chk1("fl_head_valid", rsp_valid, 1'b1);
    tick();
    flush     = 1'b0;
    req_addr  = BASE;
    rsp_ready = 1'b1;
    #1;
    chk1("fl_after_valid", rsp_valid, 1'b0);
    chk1("fl_after_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    #1;
    chk1("fl_no_stale", rsp_valid, 1'b0);
    tick();
    chk_rsp("fl_rsp", BASE, model[0], 1'b0);
    tick();
    chk1("fl_idle", rsp_valid, 1'b0);

    // Load/read collision on word 5
    load_en   = 1'b1;
    load_addr = BASE + 32'd20;
    load_data = 32'h0000_0022;
    req_valid = 1'b1;
    req_addr  = BASE + 32'd20;
    #1;
    chk1("col_ready", req_ready, 1'b1);
    tick();
    load_en = 1'b0;
    #1;
    chk1("col_ready2", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk_rsp("col_old", BASE + 32'd20, 32'h0000_0011, 1'b0);
    tick();
    chk_rsp("col_new", BASE + 32'd20, 32'h0000_0022, 1'b0);
    model[5] = 32'h0000_0022;
    tick();
    chk1("col_idle", rsp_valid, 1'b0);

    // Reset with three outstanding responses
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_addr  = BASE + 32'(4 * k);
      #1;
      chk1("mr_fill_ready", req_ready, 1'b1);
      tick();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk1("mr_ready", req_ready, 1'b0);
    chk1("mr_valid", rsp_valid, 1'b0);
    tick();
    chk1("mr_valid2", rsp_valid, 1'b0);
    chk("mr_addr", rsp_addr, 32'h0);
    chk("mr_insn", rsp_insn, 32'h0);
    chk1("mr_fault", rsp_fault, 1'b0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk1("mr_post_ready", req_ready, 1'b1);
    chk1("mr_post_valid", rsp_valid, 1'b0);
    tick();
    chk1("mr_no_stale1", rsp_valid, 1'b0);
    tick();
    chk1("mr_no_stale2", rsp_valid, 1'b0);
    req_valid = 1'b1;
    req_addr  = BASE + 32'd4;
    tick();
    req_addr  = BASE + 32'd20;
    tick();
    req_valid = 1'b0;
    chk_rsp("mr_keep1", BASE + 32'd4, model[1], 1'b0);
    tick();
    chk_rsp("mr_keep5", BASE + 32'd20, model[5], 1'b0);
    tick();
    chk1("mr_idle", rsp_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
